// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG quantiser back-end.
package jpeg_pkg;

   localparam int unsigned FP_BIAS    = 127;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
   localparam int unsigned BLK_LEN    = 64;
   localparam int unsigned IDX_W      = 6;

   typedef struct packed {
      logic        sig;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   // Magnitude class decided in S1 and carried with the word
   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_SAT  = 2'd2
   } cls_e;

   // Unbiased exponent, signed so |x|<1 gives negative values
   function automatic logic signed [8:0] fp_unbias(input logic [7:0] exp);
      return $signed({1'b0, exp}) - $signed(9'(FP_BIAS));
   endfunction

endpackage

// File: rtl/fp_round_sat.sv
// S2/S3 datapath: align mantissa keeping the half bit, round half away from zero,
// saturate to a signed OUT_W-bit integer.
module fp_round_sat
   import jpeg_pkg::*;
#(
   parameter int unsigned OUT_W = 12
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    s1_valid,
   input  logic                    s1_sig,
   input  cls_e                    s1_cls,
   input  logic signed [8:0]       s1_e,
   input  logic [22:0]             s1_man,
   input  logic                    s2_valid,
   output logic [OUT_W-1:0]        dout
);

   localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

   logic [4:0]       shamt_c;
   logic [23:0]      mant_c;
   logic             sig2;
   cls_e             cls2;
   logic [OUT_W-1:0] r2;
   logic [OUT_W-1:0] m_c;
   logic [OUT_W-1:0] res_c;

   // Only meaningful for the norm class, where e is in -1..OUT_W-2
   assign shamt_c = 5'(9'sd22 - s1_e);
   assign mant_c  = {1'b1, s1_man} >> shamt_c;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sig2 <= 1'b0;
         cls2 <= CLS_ZERO;
         r2   <= '0;
      end else if (s1_valid) begin
         sig2 <= s1_sig;
         cls2 <= s1_cls;
         r2   <= OUT_W'(mant_c);
      end
   end

   // (r+1)>>1 written without the extra carry bit: r/2 plus the half bit
   assign m_c = {1'b0, r2[OUT_W-1:1]} + {{(OUT_W-1){1'b0}}, r2[0]};

   always_comb begin
      res_c = sig2 ? (~m_c + {{(OUT_W-1){1'b0}}, 1'b1}) : m_c;
      if (cls2 == CLS_ZERO) begin
         res_c = '0;
      end else if ((cls2 == CLS_SAT) || (!sig2 && (m_c > POS_MAX)) ||
                   (sig2 && (m_c > NEG_MAX))) begin
         res_c = sig2 ? NEG_MAX : POS_MAX;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dout <= '0;
      end else if (s2_valid) begin
         dout <= res_c;
      end
   end

endmodule

// File: rtl/quant_f2i_nb.sv
// Non-blocking float-to-int stage after the quantiser divider; tags each
// coefficient with its position in the 8x8 block. Fixed 3-cycle latency.
module quant_f2i_nb
   import jpeg_pkg::*;
#(
   parameter int unsigned OUT_W = 12
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [31:0]       din,
   input  logic              din_valid,
   input  logic              din_sob,
   output logic [OUT_W-1:0]  dout,
   output logic              dout_valid,
   output logic [5:0]        dout_idx,
   output logic              dout_last,
   output logic              sync_err
);

   fp32_t             in_f;
   logic signed [8:0] e_c;
   cls_e              cls_c;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx_c;
   logic              last_c;

   logic              v1, v2;
   logic              sig1;
   cls_e              cls1;
   logic signed [8:0] e1;
   logic [22:0]       man1;
   logic [IDX_W-1:0]  idx1, idx2;
   logic              last1, last2;

   assign in_f = din;
   assign e_c  = fp_unbias(in_f.exp);

   // S1 classification: below 0.5 flushes to zero, too large saturates
   always_comb begin
      cls_c = CLS_NORM;
      if (in_f.exp == FP_EXP_MAX) begin
         cls_c = CLS_SAT;
      end else if (in_f.exp < 8'(FP_BIAS - 1)) begin
         cls_c = CLS_ZERO;
      end else if (e_c >= $signed(9'(OUT_W - 1))) begin
         cls_c = CLS_SAT;
      end
   end

   assign idx_c  = din_sob ? '0 : cnt;
   assign last_c = (idx_c == IDX_W'(BLK_LEN - 1));

   // Block position counter; a restart mid-block is flagged sticky
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt      <= '0;
         sync_err <= 1'b0;
      end else if (din_valid) begin
         cnt <= idx_c + IDX_W'(1);
         if (din_sob && (cnt != '0)) begin
            sync_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v1    <= 1'b0;
         sig1  <= 1'b0;
         cls1  <= CLS_ZERO;
         e1    <= '0;
         man1  <= '0;
         idx1  <= '0;
         last1 <= 1'b0;
      end else begin
         v1 <= din_valid;
         if (din_valid) begin
            sig1  <= in_f.sig;
            cls1  <= cls_c;
            e1    <= e_c;
            man1  <= in_f.man;
            idx1  <= idx_c;
            last1 <= last_c;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v2    <= 1'b0;
         idx2  <= '0;
         last2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            idx2  <= idx1;
            last2 <= last1;
         end
      end
   end

   // Output stage for the tag side; dout itself comes from the datapath
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dout_valid <= 1'b0;
         dout_idx   <= '0;
         dout_last  <= 1'b0;
      end else begin
         dout_valid <= v2;
         dout_last  <= v2 & last2;
         if (v2) begin
            dout_idx <= idx2;
         end
      end
   end

   fp_round_sat #(
      .OUT_W(OUT_W)
   ) u_round_sat (
      .clk      (clk),
      .nrst     (nrst),
      .s1_valid (v1),
      .s1_sig   (sig1),
      .s1_cls   (cls1),
      .s1_e     (e1),
      .s1_man   (man1),
      .s2_valid (v2),
      .dout     (dout)
   );

endmodule

// File: tb/tb_quant_f2i_nb.sv
// Randomised self-checking bench for quant_f2i_nb against a real-arithmetic
// reference model and a block-position scoreboard.
module tb_quant_f2i_nb;

   localparam int unsigned OUT_W = 12;
   localparam int POS_SAT = (1 << (OUT_W - 1)) - 1;
   localparam int NEG_SAT = -(1 << (OUT_W - 1));

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic [31:0]       din;
   logic              din_valid;
   logic              din_sob;
   logic [OUT_W-1:0]  dout;
   logic              dout_valid;
   logic [5:0]        dout_idx;
   logic              dout_last;
   logic              sync_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mcnt = 0;
   int merr = 0;

   typedef struct {
      int val;
      int idx;
      int last;
      int due;
   } exp_t;
   exp_t sbq[$];

   quant_f2i_nb #(.OUT_W(OUT_W)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .din        (din),
      .din_valid  (din_valid),
      .din_sob    (din_sob),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_idx   (dout_idx),
      .dout_last  (dout_last),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Value-level reference: round |x| half away from zero, clamp to OUT_W bits
   function automatic int ref_q(input logic [31:0] x);
      int  ex;
      int  m;
      real mag;
      ex = int'(x[30:23]);
      if (ex == 255) return x[31] ? NEG_SAT : POS_SAT;
      if (ex == 0) return 0;
      mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
      if (mag >= 2.0 ** (OUT_W - 1)) return x[31] ? NEG_SAT : POS_SAT;
      m = int'($floor(mag + 0.5));
      if (m == 0) return 0;
      if (!x[31] && m > POS_SAT) return POS_SAT;
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0:       ;
         1:       w[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
         default: w[30:23] = 8'($urandom_range(118, 140));
      endcase
      return w;
   endfunction

   // Drive one valid word for one cycle and record what must come out
   task automatic push_word(input logic [31:0] w, input logic sob, input int expv);
      int idx;
      din       = w;
      din_valid = 1'b1;
      din_sob   = sob;
      if (sob) begin
         if (mcnt != 0) merr = 1;
         idx = 0;
      end else begin
         idx = mcnt;
      end
      mcnt = (idx + 1) % 64;
      sbq.push_back('{expv, idx, int'(idx == 63), cyc + 3});
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] w, input logic sob);
      push_word(w, sob, ref_q(w));
   endtask

   // Bubbles carry junk data and sob, which must be ignored
   task automatic idle(input int n);
      repeat (n) begin
         din       = $urandom;
         din_valid = 1'b0;
         din_sob   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (nrst === 1'b1 && dout_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("dout", int'($signed(dout)), e.val);
            check("idx", int'(dout_idx), e.idx);
            check("last", int'(dout_last), e.last);
            check("latency", cyc, e.due);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [31:0] dir_w [10];
   int          dir_e [10];

   initial begin
      logic [31:0] w;
      dir_w = '{32'h41200000, 32'hC0200000, 32'h3F000000, 32'h3EFFFFFF, 32'h80000000,
                32'h44FFF000, 32'hC4FFF000, 32'h45000000, 32'hFF800000, 32'h7FC00000};
      dir_e = '{10, -3, 1, 0, 0, 2047, -2048, 2047, -2048, 2047};
      din = '0; din_valid = 1'b0; din_sob = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(dout_valid), 0);
      check("rst_dout", int'(dout), 0);
      check("rst_idx", int'(dout_idx), 0);
      check("rst_last", int'(dout_last), 0);
      check("rst_sync_err", int'(sync_err), 0);
      nrst = 1'b1;
      idle(2);

      // Directed values, then complete the block
      for (int i = 0; i < 10; i++) push_word(dir_w[i], i == 0, dir_e[i]);
      for (int i = 10; i < 64; i++) send(rnd_word(), 1'b0);
      idle(5);
      check("drain_directed", sbq.size(), 0);
      check("sync_err_clean", int'(sync_err), merr);

      // Dense block with sob at counter 0
      for (int i = 0; i < 64; i++) send(rnd_word(), i == 0);
      idle(5);
      check("drain_dense", sbq.size(), 0);
      check("sync_err_sob0", int'(sync_err), merr);

      // Two blocks with random bubbles
      for (int i = 0; i < 128; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send(rnd_word(), i == 0);
      end
      idle(5);
      check("drain_bubbles", sbq.size(), 0);

      // Restart at idx 10 raises the sticky error
      for (int i = 0; i < 10; i++) send(rnd_word(), i == 0);
      send(rnd_word(), 1'b1);
      idle(3);
      check("sync_err_set", int'(sync_err), merr);
      for (int i = 1; i < 64; i++) send(rnd_word(), 1'b0);
      send(rnd_word(), 1'b1);
      idle(5);
      check("sync_err_sticky", int'(sync_err), merr);
      check("drain_restart", sbq.size(), 0);

      // Asynchronous reset with words in flight
      send(rnd_word(), 1'b0);
      w = rnd_word();
      send(w, 1'b0);
      din_valid = 1'b0;
      nrst = 1'b0;
      #1;
      check("midrst_valid", int'(dout_valid), 0);
      check("midrst_dout", int'(dout), 0);
      check("midrst_sync_err", int'(sync_err), 0);
      sbq.delete();
      mcnt = 0;
      merr = 0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      idle(1);
      send(32'h41200000, 1'b1);
      send(32'hC0200000, 1'b0);
      idle(6);
      check("drain_after_rst", sbq.size(), 0);
      check("sync_err_after_rst", int'(sync_err), merr);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
